// File: rtl/led_pwm_fader.sv
// PWM LED fader: turns the blinker's on/off request into a PWM drive whose
// brightness ramps linearly toward full on or full off, one level per step tick.
module led_pwm_fader #(
  parameter int PWM_BITS = 4,
  parameter int STEP_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                led_in,
  output logic                pwm_out,
  output logic [PWM_BITS:0]   level,
  output logic                busy
);

  localparam int PER_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS:0]   MAX_LEVEL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [PWM_BITS-1:0] CNT_TOP   = '1;
  localparam logic [PER_W-1:0]    PER_TOP   = PER_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    OFF,
    RAMP_UP,
    ON,
    RAMP_DOWN
  } state_t;

  state_t              state;
  state_t              state_n;
  logic                led_q;
  logic [PWM_BITS-1:0] cnt;
  logic [PER_W-1:0]    per_cnt;
  logic [PWM_BITS:0]   level_n;
  logic                wrap;
  logic                step_tick;

  // Steps land only on the PWM counter wrap, so each period keeps one duty.
  assign wrap      = (cnt == CNT_TOP);
  assign step_tick = wrap && (per_cnt == PER_TOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= 1'b0;
      cnt     <= '0;
      per_cnt <= '0;
      level   <= '0;
      state   <= OFF;
      pwm_out <= 1'b0;
    end else begin
      led_q   <= led_in;
      cnt     <= cnt + 1'b1;
      if (step_tick)
        per_cnt <= '0;
      else if (wrap)
        per_cnt <= per_cnt + 1'b1;
      level   <= level_n;
      state   <= state_n;
      pwm_out <= ({1'b0, cnt} < level);
    end
  end

  // The level step follows the pre-edge state; the new state follows led_q.
  always_comb begin
    level_n = level;
    state_n = state;
    if (step_tick) begin
      if (state == RAMP_UP && level != MAX_LEVEL)
        level_n = level + 1'b1;
      else if (state == RAMP_DOWN && level != '0)
        level_n = level - 1'b1;
    end
    case (state)
      OFF: begin
        if (led_q) state_n = RAMP_UP;
      end
      RAMP_UP: begin
        if (!led_q)                  state_n = RAMP_DOWN;
        else if (level_n == MAX_LEVEL) state_n = ON;
      end
      ON: begin
        if (!led_q) state_n = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (led_q)              state_n = RAMP_UP;
        else if (level_n == '0) state_n = OFF;
      end
      default: state_n = OFF;
    endcase
  end

  assign busy = (state == RAMP_UP) || (state == RAMP_DOWN);

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader: a small (PWM_BITS=2, STEP_DIV=1) instance
// against a target-tracking reference model, plus a default-parameter timing instance.
module tb_led_pwm_fader;

  localparam int PA   = 2;
  localparam int SA   = 1;
  localparam int MAXA = 4;
  localparam int PB   = 4;
  localparam int SB   = 2;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a = 1'b1;
  logic          led_a = 1'b0;
  logic          pwm_a;
  logic          busy_a;
  logic [PA:0]   level_a;
  logic          rst_b = 1'b1;
  logic          led_b = 1'b0;
  logic          pwm_b;
  logic          busy_b;
  logic [PB:0]   level_b;

  int checks = 0;
  int fails  = 0;

  led_pwm_fader #(.PWM_BITS(PA), .STEP_DIV(SA)) dut_a (
    .clk(clk), .rst(rst_a), .led_in(led_a),
    .pwm_out(pwm_a), .level(level_a), .busy(busy_a)
  );

  led_pwm_fader #(.PWM_BITS(PB), .STEP_DIV(SB)) dut_b (
    .clk(clk), .rst(rst_b), .led_in(led_b),
    .pwm_out(pwm_b), .level(level_b), .busy(busy_b)
  );

  // Reference: level walks one step per period toward the request seen two edges ago.
  int m_t, m_req1, m_dir, m_level, m_pwm;
  always @(posedge clk) begin
    if (rst_a) begin
      m_t = 0; m_req1 = 0; m_dir = 0; m_level = 0; m_pwm = 0;
    end else begin
      m_pwm = ((m_t % MAXA) < m_level) ? 1 : 0;
      if ((m_t % (MAXA * SA)) == MAXA * SA - 1)
        m_level = m_dir ? ((m_level < MAXA) ? m_level + 1 : MAXA)
                        : ((m_level > 0) ? m_level - 1 : 0);
      m_dir  = m_req1;
      m_req1 = int'(led_a);
      m_t++;
    end
  end

  function automatic logic m_busy();
    return (m_dir != 0) ? (m_level != MAXA) : (m_level != 0);
  endfunction

  task automatic apply_reset_a(input int n);
    @(negedge clk);
    rst_a = 1'b1;
    repeat (n) @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    @(negedge clk);
    rst_a = 1'b1;
    led_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (pwm_a !== 1'b0) begin fails++; $display("[TB] FAIL reset_pwm cyc=%0d got=%b exp=0", i, pwm_a); end
      checks++; if (level_a !== '0) begin fails++; $display("[TB] FAIL reset_level cyc=%0d got=%0d exp=0", i, level_a); end
      checks++; if (busy_a !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy cyc=%0d got=%b exp=0", i, busy_a); end
    end
    rst_a = 1'b0;
    e = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (busy_a === 1'b1) begin e = i; break; end
    end
    checks++; if (e < 1 || e > 2) begin fails++; $display("[TB] FAIL reset_release_busy edges got=%0d exp<=2", e); end
  endtask

  task automatic test_ramp_up();
    logic [PA:0] lv[30];
    logic        pw[30];
    logic        bz[30];
    int i1, highs, ones;
    led_a = 1'b0;
    apply_reset_a(2);
    led_a = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lv[i] = level_a; pw[i] = pwm_a; bz[i] = busy_a;
      checks++; if (level_a !== 3'(m_level)) begin fails++; $display("[TB] FAIL ramp_level cyc=%0d got=%0d exp=%0d", i, level_a, m_level); end
      checks++; if (pwm_a !== 1'(m_pwm)) begin fails++; $display("[TB] FAIL ramp_pwm cyc=%0d got=%b exp=%0d", i, pwm_a, m_pwm); end
      checks++; if (busy_a !== m_busy()) begin fails++; $display("[TB] FAIL ramp_busy cyc=%0d got=%b exp=%b", i, busy_a, m_busy()); end
    end
    checks++; if (bz[1] !== 1'b1) begin fails++; $display("[TB] FAIL ramp_busy_rise got=%b exp=1", bz[1]); end
    i1 = -1;
    for (int i = 0; i < 30; i++) if (lv[i] == 3'd1) begin i1 = i; break; end
    checks++;
    if (i1 < 0 || i1 > 10) begin
      fails++; $display("[TB] FAIL ramp_first_step index got=%0d exp<=10", i1);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (lv[i1 + 4 * k] !== 3'(k + 1)) begin fails++; $display("[TB] FAIL ramp_step%0d level got=%0d exp=%0d", k, lv[i1 + 4 * k], k + 1); end
        highs = 0;
        for (int j = 1; j <= 4; j++) highs += int'(pw[i1 + 4 * k + j]);
        checks++; if (highs != k + 1) begin fails++; $display("[TB] FAIL ramp_duty%0d highs got=%0d exp=%0d", k, highs, k + 1); end
      end
      checks++; if (bz[i1 + 12] !== 1'b0) begin fails++; $display("[TB] FAIL ramp_done_busy got=%b exp=0", bz[i1 + 12]); end
      ones = 0;
      for (int j = i1 + 13; j < 30; j++) ones += int'(pw[j]);
      checks++; if (ones != 30 - (i1 + 13)) begin fails++; $display("[TB] FAIL ramp_full_on highs got=%0d exp=%0d", ones, 30 - (i1 + 13)); end
    end
  endtask

  task automatic test_reversal();
    int found, peak, seen1;
    led_a = 1'b0;
    apply_reset_a(2);
    led_a = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (level_a == 3'd2) begin found = 1; break; end
    end
    checks++; if (found == 0) begin fails++; $display("[TB] FAIL rev_reach2 got=%0d exp=2", level_a); end
    led_a = 1'b0;
    peak = 0; seen1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (int'(level_a) > peak) peak = int'(level_a);
      if (level_a == 3'd1) seen1 = 1;
      checks++; if (level_a !== 3'(m_level)) begin fails++; $display("[TB] FAIL rev_level cyc=%0d got=%0d exp=%0d", i, level_a, m_level); end
    end
    checks++; if (peak >= 3) begin fails++; $display("[TB] FAIL rev_peak got=%0d exp<3", peak); end
    checks++; if (seen1 == 0) begin fails++; $display("[TB] FAIL rev_pass_1 got=0 exp=1"); end
    checks++; if (level_a !== '0) begin fails++; $display("[TB] FAIL rev_final_level got=%0d exp=0", level_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("[TB] FAIL rev_final_busy got=%b exp=0", busy_a); end
    checks++; if (pwm_a !== 1'b0) begin fails++; $display("[TB] FAIL rev_final_pwm got=%b exp=0", pwm_a); end
  endtask

  task automatic test_short_pulse();
    int peak, highs;
    led_a = 1'b0;
    apply_reset_a(2);
    repeat ($urandom_range(0, 7)) @(negedge clk);
    led_a = 1'b1;
    @(negedge clk);
    led_a = 1'b0;
    peak = 0; highs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (int'(level_a) > peak) peak = int'(level_a);
      highs += int'(pwm_a);
      checks++; if (pwm_a !== 1'(m_pwm)) begin fails++; $display("[TB] FAIL pulse_pwm cyc=%0d got=%b exp=%0d", i, pwm_a, m_pwm); end
    end
    checks++; if (peak > 1) begin fails++; $display("[TB] FAIL pulse_peak got=%0d exp<=1", peak); end
    checks++; if (highs > 1) begin fails++; $display("[TB] FAIL pulse_highs got=%0d exp<=1", highs); end
    checks++; if (level_a !== '0) begin fails++; $display("[TB] FAIL pulse_final_level got=%0d exp=0", level_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("[TB] FAIL pulse_final_busy got=%b exp=0", busy_a); end
  endtask

  task automatic test_mid_reset();
    int found;
    led_a = 1'b0;
    apply_reset_a(2);
    led_a = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (level_a == 3'd3) begin found = 1; break; end
    end
    checks++; if (found == 0) begin fails++; $display("[TB] FAIL midrst_reach3 got=%0d exp=3", level_a); end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    checks++; if (level_a !== '0) begin fails++; $display("[TB] FAIL midrst_level got=%0d exp=0", level_a); end
    checks++; if (pwm_a !== 1'b0) begin fails++; $display("[TB] FAIL midrst_pwm got=%b exp=0", pwm_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy_a); end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++; if (level_a !== 3'(m_level)) begin fails++; $display("[TB] FAIL midrst_after_level cyc=%0d got=%0d exp=%0d", i, level_a, m_level); end
      checks++; if (pwm_a !== 1'(m_pwm)) begin fails++; $display("[TB] FAIL midrst_after_pwm cyc=%0d got=%b exp=%0d", i, pwm_a, m_pwm); end
    end
  endtask

  task automatic test_random();
    int hold;
    led_a = 1'b0;
    apply_reset_a(2);
    hold = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      checks++; if (level_a !== 3'(m_level)) begin fails++; $display("[TB] FAIL rand_level cyc=%0d got=%0d exp=%0d", i, level_a, m_level); end
      checks++; if (pwm_a !== 1'(m_pwm)) begin fails++; $display("[TB] FAIL rand_pwm cyc=%0d got=%b exp=%0d", i, pwm_a, m_pwm); end
      checks++; if (busy_a !== m_busy()) begin fails++; $display("[TB] FAIL rand_busy cyc=%0d got=%b exp=%b", i, busy_a, m_busy()); end
      if (hold == 0) begin
        led_a = 1'($urandom_range(0, 1));
        hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
      end else begin
        hold--;
      end
      rst_a = ($urandom_range(0, 299) == 0);
    end
    rst_a = 1'b0;
  endtask

  task automatic test_defaults_timing();
    int cycles, prev, incs, last_t, reached;
    @(negedge clk);
    rst_b = 1'b1;
    led_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    led_b = 1'b1;
    cycles = 0; prev = 0; incs = 0; last_t = 0; reached = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      cycles++;
      if (int'(level_b) != prev) begin
        checks++; if (int'(level_b) != prev + 1) begin fails++; $display("[TB] FAIL dflt_step_size got=%0d exp=%0d", level_b, prev + 1); end
        incs++;
        if (incs > 1) begin
          checks++; if (cycles - last_t != 32) begin fails++; $display("[TB] FAIL dflt_step_gap%0d got=%0d exp=32", incs, cycles - last_t); end
        end
        last_t = cycles;
        prev = int'(level_b);
        if (level_b == 5'(MAXB)) begin reached = 1; break; end
      end
    end
    checks++; if (reached == 0) begin fails++; $display("[TB] FAIL dflt_reach_max got=%0d exp=%0d", level_b, MAXB); end
    checks++; if (cycles < 496 || cycles > 530) begin fails++; $display("[TB] FAIL dflt_ramp_time got=%0d exp=496..530", cycles); end
    checks++; if (incs != 16) begin fails++; $display("[TB] FAIL dflt_increments got=%0d exp=16", incs); end
    repeat (3) @(negedge clk);
    checks++; if (busy_b !== 1'b0) begin fails++; $display("[TB] FAIL dflt_busy_done got=%b exp=0", busy_b); end
    checks++; if (pwm_b !== 1'b1) begin fails++; $display("[TB] FAIL dflt_pwm_full got=%b exp=1", pwm_b); end
  endtask

  initial begin
    $display("[TB] led_pwm_fader bench start");
    test_reset();
    test_ramp_up();
    test_reversal();
    test_short_pulse();
    test_mid_reset();
    test_random();
    test_defaults_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout checks=%0d fails=%0d", checks, fails);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Downstream stage of the blinky LED generator.
- Consumes the raw on/off `led` signal and drives the physical LED pin through a PWM output.
- Instead of switching hard, brightness ramps linearly up on a rising `led` and down on a falling `led`.
- Single clock domain, the same `clk` that drives the blinker.

Parameters:
- PWM_BITS, 4: PWM counter width. PWM period = 2^PWM_BITS cycles. MAX level = 2^PWM_BITS.
- STEP_DIV, 2: number of PWM periods per one-level brightness step. Must be ≥ 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- led_in  input  1  raw on/off request from the blinker, same clock domain.
- pwm_out  output  1  registered PWM drive to the LED pin.
- level  output  PWM_BITS+1  current brightness, range 0..MAX.
- busy  output  1  high while ramping.

Behaviour:
- Reset (rst=1 at an edge):
  - led_q=0, cnt=0, period counter=0, level=0, state=OFF, pwm_out=0, busy=0.
  - Reset overrides everything, including mid-ramp.
- Input stage: led_q <= led_in every edge. State logic uses only led_q.
- PWM counter: cnt is PWM_BITS wide, free-running, increments every edge and wraps 2^PWM_BITS-1 -> 0.
- Step tick:
  - The period counter (0..STEP_DIV-1) advances when cnt == 2^PWM_BITS-1.
  - step_tick = (cnt == 2^PWM_BITS-1) && (period counter == STEP_DIV-1).
  - Period counter wraps to 0 on step_tick.
- State machine, 4 states, registered:
  - OFF: level=0. If led_q=1 -> RAMP_UP.
  - RAMP_UP:
    - If led_q=0 -> RAMP_DOWN (reverse from current level, no reset of level).
    - Else on step_tick, level+1; when level reaches MAX -> ON.
  - ON: level=MAX. If led_q=0 -> RAMP_DOWN.
  - RAMP_DOWN:
    - If led_q=1 -> RAMP_UP.
    - Else on step_tick, level-1; when level reaches 0 -> OFF.
- Simultaneous events:
  - When a direction change and step_tick occur on the same edge, the level step uses the direction of the state register before the edge, and the state takes the new direction.
  - Level never goes below 0 or above MAX.
- Output timing:
  - pwm_out <= (cnt < level), compared at full width with cnt zero-extended. This gives 1-cycle latency.
  - level=0 gives pwm_out constantly 0; level=MAX gives pwm_out constantly 1.
  - Level changes only on step_tick (at cnt wrap), so every PWM period has a single constant duty.
- busy = (state == RAMP_UP) || (state == RAMP_DOWN), decoded combinationally from the state register.
  - busy rises no later than the 2nd edge after led_in changes.
- Full ramp duration = MAX × STEP_DIV × 2^PWM_BITS cycles. Defaults: 16 × 2 × 16 = 512 cycles.
- Changes of led_in shorter than 1 cycle are not seen. Any pulse held across an edge is honoured.

Test Plan:
- Reset (PWM_BITS=2, STEP_DIV=1):
  - Stimulus: hold rst=1 for 3 cycles with led_in=1.
  - Required: pwm_out=0, level=0, busy=0 throughout.
  - After release, ramp starts within 2 edges.
- Ramp up (PWM_BITS=2, STEP_DIV=1):
  - Stimulus: led_in 0->1 after reset.
  - Required: busy=1 within 2 edges. level steps 1,2,3,4, one step per 4-cycle period.
  - Required: pwm_out high for 1,2,3,4 cycles in successive periods.
  - Required: busy=0 once level=4, then pwm_out stays 1.
- Reversal (PWM_BITS=2, STEP_DIV=1):
  - Stimulus: drop led_in to 0 while level=2 in RAMP_UP.
  - Required: level never reaches 3. level goes 1 then 0. state returns to OFF, busy=0, pwm_out=0.
- Short pulse (PWM_BITS=2, STEP_DIV=1):
  - Stimulus: from OFF, led_in high for exactly 1 cycle.
  - Required: level peaks at ≤1 and returns to 0. No glitch beyond a single period of duty 1/4.
- Mid-ramp reset (PWM_BITS=2, STEP_DIV=1):
  - Stimulus: assert rst for 1 cycle at level=3.
  - Required: next edge level=0, cnt=0, pwm_out=0, busy=0, state OFF.
- Defaults timing:
  - Stimulus: led_in 0->1 with PWM_BITS=4, STEP_DIV=2.
  - Required: level reaches 16 between 496 and 530 cycles after the change.
  - Required: exactly 16 level increments, each 32 cycles apart.
